hazard_stall_controller: RTL

- Pipeline sequencing controller for the 5-stage MIPS core; sits beside the forwarding unit in ID.
- Decides when IF/ID freeze and ID/EX receives a bubble: load-use hazards, ID-resolved branch operand hazards, and structural/data hazards on the shared iterative multiply/divide unit and HI/LO.
- Owns the mult/div sequencing FSM, which issues start, counts latency, and commits HI/LO.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 6 +
 rtl/md_sequencer.sv | 55 +++++
 rtl/hazard_stall_controller.sv | 61 ++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared md_op encodings, mult/div FSM states and register constants
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {MD_NONE = 2'b00, MD_MUL = 2'b01, MD_DIV = 2'b10} md_op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_COMMIT} md_state_e;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/md_sequencer.sv
// md_sequencer: mult/div issue/latency/commit FSM; start_req,is_div in; md_start,md_is_div,hilo_we,busy out
module md_sequencer #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_req,
  input  logic is_div,
  output logic md_start,
  output logic md_is_div,
  output logic hilo_we,
  output logic busy
);
  import pipe_ctrl_pkg::*;
  localparam logic [5:0] MUL_LD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LD = 6'(DIV_CYCLES - 1);
  md_state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d, ld;
  logic is_div_q, is_div_d;
  // COMMIT is the last busy cycle, so BUSY lasts N-1 cycles and a 1-cycle op goes straight to COMMIT
  always_comb begin
    md_start = rst_n & start_req & (state_q == ST_IDLE);
    ld = is_div ? DIV_LD : MUL_LD;
    state_d = state_q;
    cnt_d = cnt_q;
    is_div_d = is_div_q;
    case (state_q)
      ST_IDLE: if (md_start) begin
        cnt_d = ld;
        is_div_d = is_div;
        state_d = (ld == 6'd0) ? ST_COMMIT : ST_BUSY;
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 6'd1;
        state_d = (cnt_q == 6'd1) ? ST_COMMIT : ST_BUSY;
      end
      default: state_d = ST_IDLE;
    endcase
    md_is_div = (state_q == ST_IDLE) ? is_div : is_div_q;
    hilo_we = rst_n & (state_q == ST_COMMIT);
    busy = rst_n & (state_q != ST_IDLE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q <= 6'd0;
      is_div_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      is_div_q <= is_div_d;
    end
  end
endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: ID-stage stall/bubble control for load-use, branch and mult/div hazards, plus stall counter
module hazard_stall_controller #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_uses_rs,
  input  logic             ID_uses_rt,
  input  logic             ID_branch,
  input  logic [1:0]       ID_md_op,
  input  logic             ID_reads_hilo,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_RegWrite,
  input  logic [4:0]       ID_EX_rd,
  input  logic             EX_MEM_MemRead,
  input  logic [4:0]       EX_MEM_rd,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_Flush,
  output logic             md_start,
  output logic             md_is_div,
  output logic             hilo_we,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_count
);
  import pipe_ctrl_pkg::*;
  logic ex_hit, mem_hit, lb_hazard, md_hazard, stall, md_req, md_div;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  always_comb begin
    ex_hit = (ID_EX_rd != REG_ZERO) & ((ID_uses_rs & (ID_rs == ID_EX_rd)) | (ID_uses_rt & (ID_rt == ID_EX_rd)));
    mem_hit = (EX_MEM_rd != REG_ZERO) & ((ID_uses_rs & (ID_rs == EX_MEM_rd)) | (ID_uses_rt & (ID_rt == EX_MEM_rd)));
    lb_hazard = (ID_EX_MemRead & ex_hit) | (ID_branch & ID_EX_RegWrite & ex_hit) | (ID_branch & EX_MEM_MemRead & mem_hit);
    md_hazard = md_busy & ((ID_md_op != MD_NONE) | ID_reads_hilo);
    stall = lb_hazard | md_hazard;
    md_div = ID_md_op == MD_DIV;
    md_req = ((ID_md_op == MD_MUL) | md_div) & ~lb_hazard;
    PCWrite = ~stall;
    IF_ID_Write = ~stall;
    ID_EX_Flush = stall;
    stall_count_d = (stall & ~&stall_count_q) ? stall_count_q + CNT_W'(1) : stall_count_q;
    stall_count = stall_count_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) stall_count_q <= '0;
    else stall_count_q <= stall_count_d;
  end
  md_sequencer #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_seq (
    .clk(clk),
    .rst_n(rst_n),
    .start_req(md_req),
    .is_div(md_div),
    .md_start(md_start),
    .md_is_div(md_is_div),
    .hilo_we(hilo_we),
    .busy(md_busy)
  );
endmodule
